// File: rtl/byte_packer.sv
// Purpose : packs a ready/valid byte stream into N_BYTES-wide words, byte lane k = bits [8k+7:8k].
// Latency : 1 cycle from the completing byte's handshake to io_out_valid.
// Backpr. : one registered output word. io_in_ready drops while that word is stalled,
//           and assembly holds until the word drains. A drain and a new completion on the
//           same edge give back-to-back words with no bubble.
// Ports   : clock/reset (async, active-low); io_in_{valid,ready,bits,last} byte side;
//           io_out_{valid,ready,bits,mask} word side; io_offset = lane of the next accepted byte.
module byte_packer #(
    parameter  int N_BYTES = 4,
    localparam int OFFW    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1,
    localparam int DW      = 8 * N_BYTES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [7:0]        io_in_bits,
    input  logic              io_in_last,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DW-1:0]     io_out_bits,
    output logic [N_BYTES-1:0] io_out_mask,
    output logic [OFFW-1:0]   io_offset
);

    // Assembly register: the word being built
    logic [DW-1:0]      acc_q, acc_d;
    logic [N_BYTES-1:0] amask_q, amask_d;
    logic [OFFW-1:0]    cnt_q, cnt_d;

    // Output register: the finished word offered downstream
    logic [DW-1:0]      obits_q, obits_d;
    logic [N_BYTES-1:0] omask_q, omask_d;
    logic               ovalid_q, ovalid_d;

    logic               in_ready;
    logic               accept;
    logic               complete;
    logic [DW-1:0]      merged_bits;
    logic [N_BYTES-1:0] merged_mask;

    // Depends only on the output register and io_out_ready.
    // There is no combinational path from io_in_* to io_in_ready.
    assign in_ready = !ovalid_q || io_out_ready;

    always_comb begin
        accept   = io_in_valid && in_ready;
        complete = accept && ((cnt_q == OFFW'(N_BYTES - 1)) || io_in_last);

        // The assembly word with the incoming byte dropped into lane cnt
        merged_bits = acc_q;
        merged_mask = amask_q;
        for (int k = 0; k < N_BYTES; k++) begin
            if (cnt_q == OFFW'(k)) begin
                merged_bits[8*k +: 8] = io_in_bits;
                merged_mask[k]        = 1'b1;
            end
        end

        acc_d    = acc_q;
        amask_d  = amask_q;
        cnt_d    = cnt_q;
        obits_d  = obits_q;
        omask_d  = omask_q;
        ovalid_d = ovalid_q;

        if (ovalid_q && io_out_ready) begin
            ovalid_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                // A completion in the same cycle as a drain overrides the clear above.
                obits_d  = merged_bits;
                omask_d  = merged_mask;
                ovalid_d = 1'b1;
                // Clearing acc here keeps unwritten lanes of the next word at zero.
                acc_d    = '0;
                amask_d  = '0;
                cnt_d    = '0;
            end else begin
                acc_d    = merged_bits;
                amask_d  = merged_mask;
                cnt_d    = cnt_q + OFFW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            amask_q  <= '0;
            cnt_q    <= '0;
            obits_q  <= '0;
            omask_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            amask_q  <= amask_d;
            cnt_q    <= cnt_d;
            obits_q  <= obits_d;
            omask_q  <= omask_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign io_in_ready  = in_ready;
    assign io_out_valid = ovalid_q;
    assign io_out_bits  = obits_q;
    assign io_out_mask  = omask_q;
    assign io_offset    = cnt_q;

endmodule

// File: tb/tb_byte_packer.sv
// Purpose : self-checking bench for byte_packer: directed scenarios and a random stream,
//           checked against a queue-based model of the packing rules.
// Latency : inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
// Backpr. : io_out_ready is driven both directed and random.
module tb_byte_packer;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [7:0]  io_in_bits;
    logic        io_in_last;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_bits;
    logic [3:0]  io_out_mask;
    logic [1:0]  io_offset;

    byte_packer #(.N_BYTES(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_in_last   (io_in_last),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_out_mask  (io_out_mask),
        .io_offset    (io_offset)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model state: bytes of the word in progress, plus the word waiting downstream.
    logic [7:0]  pend[$];
    logic        m_has_out = 1'b0;
    logic [31:0] m_obits;
    logic [3:0]  m_omask;
    // Words seen leaving the DUT, used by the directed checks.
    logic [31:0] seen_bits[$];
    logic [3:0]  seen_mask[$];

    task automatic model_step();
        logic        m_rdy;
        logic [31:0] w;
        logic [3:0]  m;
        m_rdy = !m_has_out || io_out_ready;
        chk("in_ready",  64'(io_in_ready),  64'(m_rdy));
        chk("out_valid", 64'(io_out_valid), 64'(m_has_out));
        chk("offset",    64'(io_offset),    64'(pend.size()));
        if (m_has_out) begin
            chk("out_bits", 64'(io_out_bits), 64'(m_obits));
            chk("out_mask", 64'(io_out_mask), 64'(m_omask));
        end
        if (m_has_out && io_out_ready) begin
            seen_bits.push_back(io_out_bits);
            seen_mask.push_back(io_out_mask);
            m_has_out = 1'b0;
        end
        if (io_in_valid && m_rdy) begin
            pend.push_back(io_in_bits);
            if (pend.size() == N || io_in_last) begin
                w = '0;
                m = '0;
                foreach (pend[k]) begin
                    w = w | (32'(pend[k]) << (8 * k));
                    m[k] = 1'b1;
                end
                m_obits   = w;
                m_omask   = m;
                m_has_out = 1'b1;
                pend.delete();
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] b, input logic l, input logic ordy);
        io_in_valid  = v;
        io_in_bits   = b;
        io_in_last   = l;
        io_out_ready = ordy;
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},  64'(io_out_valid), 64'(0));
        chk({tag, "_bits"},   64'(io_out_bits),  64'(0));
        chk({tag, "_mask"},   64'(io_out_mask),  64'(0));
        chk({tag, "_offset"}, 64'(io_offset),    64'(0));
        chk({tag, "_ready"},  64'(io_in_ready),  64'(1));
    endtask

    int s;

    initial begin
        reset = 1'b0; io_in_valid = 0; io_in_bits = 0; io_in_last = 0; io_out_ready = 1;
        #3;
        chk_reset_outputs("rst");
        @(posedge clock); #1;
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;

        // Four bytes -> one full word
        s = seen_bits.size();
        cycle(1, 8'h11, 0, 1); cycle(1, 8'h22, 0, 1);
        cycle(1, 8'h33, 0, 1); cycle(1, 8'h44, 0, 1);
        cycle(0, 8'h00, 0, 1); cycle(0, 8'h00, 0, 1);
        chk("tp1_count", 64'(seen_bits.size() - s), 64'(1));
        if (seen_bits.size() > s) begin
            chk("tp1_bits", 64'(seen_bits[s]), 64'h44332211);
            chk("tp1_mask", 64'(seen_mask[s]), 64'hF);
        end

        // Eight bytes streamed continuously -> two words without a bubble
        s = seen_bits.size();
        for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0, 1);
        cycle(0, 8'h00, 0, 1); cycle(0, 8'h00, 0, 1);
        chk("tp2_count", 64'(seen_bits.size() - s), 64'(2));
        if (seen_bits.size() >= s + 2) begin
            chk("tp2_w0", 64'(seen_bits[s]),   64'h04030201);
            chk("tp2_w1", 64'(seen_bits[s+1]), 64'h08070605);
        end

        // Early flush after two bytes
        s = seen_bits.size();
        cycle(1, 8'hAA, 0, 1); cycle(1, 8'hBB, 1, 1);
        cycle(0, 8'h00, 0, 1);
        chk("tp3_offset", 64'(io_offset), 64'(0));
        cycle(0, 8'h00, 0, 1);
        if (seen_bits.size() > s) begin
            chk("tp3_bits", 64'(seen_bits[s]), 64'h0000BBAA);
            chk("tp3_mask", 64'(seen_mask[s]), 64'h3);
        end else chk("tp3_count", 64'(seen_bits.size() - s), 64'(1));

        // Output stall for five cycles with input offered; nothing may be lost
        s = seen_bits.size();
        cycle(1, 8'hC1, 0, 1); cycle(1, 8'hC2, 0, 1);
        cycle(1, 8'hC3, 0, 1); cycle(1, 8'hC4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'h55, 0, 0);
            chk("tp4_stall_ready", 64'(io_in_ready), 64'(0));
        end
        cycle(1, 8'h55, 0, 1);
        cycle(1, 8'h66, 0, 1); cycle(1, 8'h77, 0, 1); cycle(1, 8'h88, 0, 1);
        cycle(0, 8'h00, 0, 1); cycle(0, 8'h00, 0, 1);
        chk("tp4_count", 64'(seen_bits.size() - s), 64'(2));
        if (seen_bits.size() >= s + 2) begin
            chk("tp4_w0", 64'(seen_bits[s]),   64'hC4C3C2C1);
            chk("tp4_w1", 64'(seen_bits[s+1]), 64'h88776655);
        end

        // Asynchronous reset mid-word
        cycle(1, 8'hE1, 0, 1); cycle(1, 8'hE2, 0, 1);
        io_in_valid = 0;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("arst");
        pend.delete();
        m_has_out = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;
        s = seen_bits.size();
        cycle(1, 8'hD1, 0, 1); cycle(1, 8'hD2, 0, 1);
        cycle(1, 8'hD3, 0, 1); cycle(1, 8'hD4, 0, 1);
        cycle(0, 8'h00, 0, 1); cycle(0, 8'h00, 0, 1);
        chk("tp5_count", 64'(seen_bits.size() - s), 64'(1));
        if (seen_bits.size() > s) begin
            chk("tp5_bits", 64'(seen_bits[s]), 64'hD4D3D2D1);
            chk("tp5_mask", 64'(seen_mask[s]), 64'hF);
        end

        // Single byte with last at lane 0
        s = seen_bits.size();
        cycle(1, 8'h5A, 1, 1);
        cycle(0, 8'h00, 0, 1); cycle(0, 8'h00, 0, 1);
        if (seen_bits.size() > s) begin
            chk("tp6_bits", 64'(seen_bits[s]), 64'h0000005A);
            chk("tp6_mask", 64'(seen_mask[s]), 64'h1);
        end else chk("tp6_count", 64'(seen_bits.size() - s), 64'(1));

        // Random traffic with random backpressure and early flushes
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0, ($urandom % 3) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Inverse of the byte-select datapath: accepts a stream of bytes and packs them into 32-bit words, byte lane k = bits [8k+7:8k].
- Sits upstream of word-wide consumers (memory write port, word FIFO) that are fed from byte-serial sources.
- Ready/valid on both sides, one registered output word, sustained throughput of one byte per cycle.

Parameters:
- N_BYTES, 4, bytes per output word (2..8); output width is 8*N_BYTES and offset width is clog2(N_BYTES). Port widths below are for the default.

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  reset; one clock; reset is asynchronous and active-low
- io_in_valid  input  1  byte offered
- io_in_ready  output  1  byte accepted when io_in_valid && io_in_ready
- io_in_bits  input  8  byte data
- io_in_last  input  1  byte ends the current word early (partial flush)
- io_out_valid  output  1  packed word available
- io_out_ready  input  1  consumer takes word when io_out_valid && io_out_ready
- io_out_bits  output  32  packed word, lane k = byte k of the word
- io_out_mask  output  4  lanes written in io_out_bits, bit k = lane k
- io_offset  output  2  lane the next accepted byte will occupy

Behaviour:
- State: assembly register acc[31:0], amask[3:0], cnt[1:0] (= io_offset); output register obits, omask, ovalid.
- Reset asserted (reset==0) at any time, asynchronously: acc=0, amask=0, cnt=0, obits=0, omask=0, ovalid=0. Outputs: io_out_valid=0, io_out_bits=0, io_out_mask=0, io_offset=0, io_in_ready=1. Any word mid-assembly is discarded.
- io_in_ready = !ovalid || io_out_ready (combinational; no path from io_in_* to io_in_ready).
- Accept without completion (cnt != N_BYTES-1 and !io_in_last): write byte to lane cnt of acc, set amask[cnt], cnt += 1.
- Accept with completion (cnt == N_BYTES-1 or io_in_last): next cycle obits = acc with the byte in lane cnt, omask = amask | (1<<cnt), ovalid=1. Same edge: acc=0, amask=0, cnt=0.
- Unwritten lanes of io_out_bits are 0.
- Latency: 1 cycle from the completing byte's handshake to io_out_valid.
- Output drain: ovalid clears on io_out_valid && io_out_ready unless a completion occurs on the same edge. In that case the new word loads and ovalid stays 1, so back-to-back words have no bubble.
- Backpressure: with ovalid=1 and io_out_ready=0, io_in_ready=0, and acc, cnt and the output register hold. io_out_bits and io_out_mask are stable while io_out_valid && !io_out_ready.
- io_in_last on the final lane gives a single full word (mask 4'hF). No empty word is ever emitted.
- io_in_last on lane 0 gives mask 4'h1.
- cnt wraps N_BYTES-1 -> 0 only via completion. No overflow state exists.
- io_in_bits and io_in_last are ignored when there is no handshake.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles, io_out_ready=1 -> one cycle after 0x44: io_out_valid=1, io_out_bits=0x44332211, io_out_mask=4'hF; io_offset sequence 0,1,2,3,0.
- 8 bytes 0x01..0x08 streamed continuously, io_out_ready=1 -> words 0x04030201 then 0x08070605 with no bubble; io_in_ready stays 1 throughout.
- Bytes 0xAA,0xBB with io_in_last on 0xBB -> io_out_bits=0x0000BBAA, io_out_mask=4'h3; io_offset returns to 0.
- Word pending and io_out_ready=0 for 5 cycles while io_in_valid=1 -> io_in_ready=0, output held stable, no byte lost. Then raise io_out_ready -> word drains and input resumes the same cycle.
- Drive reset low asynchronously (mid-clock) after 2 bytes accepted -> all outputs zero immediately and io_offset=0. After release, 4 new bytes produce exactly one word containing only the new bytes.
- Single byte 0x5A with io_in_last at offset 0 -> io_out_bits=0x0000005A, io_out_mask=4'h1.
